// File: rtl/divider32bit_iterative.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// divider32bit_iterative : restoring radix-2 divider for DIV/DIVU (LO/HI)
// Revision 1.0
// ---------------------------------------------------------------------------
module divider32bit_iterative #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIVIDE = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem_acc;
   logic [WIDTH-1:0] quo_acc;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH-1:0] dividend_orig;
   logic             neg_q;
   logic             neg_r;
   logic             dbz;

   logic             dividend_neg;
   logic             divisor_neg;
   logic [WIDTH-1:0] dividend_abs;
   logic [WIDTH-1:0] divisor_abs;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   assign dividend_neg = is_signed & dividend[WIDTH-1];
   assign divisor_neg  = is_signed & divisor[WIDTH-1];
   assign dividend_abs = dividend_neg ? -dividend : dividend;
   assign divisor_abs  = divisor_neg  ? -divisor  : divisor;

   // Partial remainder is one bit wider than the operands so the trial
   // subtract's sign bit is a clean borrow indicator.
   assign shifted = {rem_acc, quo_acc[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvsr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start) state_next = S_DIVIDE;
         S_DIVIDE: if (count == LAST) state_next = S_FINISH;
         S_FINISH: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count         <= '0;
         rem_acc       <= '0;
         quo_acc       <= '0;
         dvsr          <= '0;
         dividend_orig <= '0;
         neg_q         <= 1'b0;
         neg_r         <= 1'b0;
         dbz           <= 1'b0;
         quotient      <= '0;
         remainder     <= '0;
         div_by_zero   <= 1'b0;
         done          <= 1'b0;
         busy          <= 1'b0;
      end else begin
         done <= (state == S_FINISH);
         busy <= (state_next != S_IDLE);
         case (state)
            S_IDLE: begin
               if (start) begin
                  rem_acc       <= '0;
                  quo_acc       <= dividend_abs;
                  dvsr          <= divisor_abs;
                  dividend_orig <= dividend;
                  neg_q         <= dividend_neg ^ divisor_neg;
                  neg_r         <= dividend_neg;
                  dbz           <= (divisor == '0);
                  count         <= '0;
               end
            end
            S_DIVIDE: begin
               count <= count + CW'(1);
               if (!trial[WIDTH]) begin
                  rem_acc <= trial[WIDTH-1:0];
                  quo_acc <= {quo_acc[WIDTH-2:0], 1'b1};
               end else begin
                  rem_acc <= shifted[WIDTH-1:0];
                  quo_acc <= {quo_acc[WIDTH-2:0], 1'b0};
               end
            end
            S_FINISH: begin
               // Divide-by-zero result is forced so signed mode matches unsigned.
               div_by_zero <= dbz;
               if (dbz) begin
                  quotient  <= '1;
                  remainder <= dividend_orig;
               end else begin
                  quotient  <= neg_q ? -quo_acc : quo_acc;
                  remainder <= neg_r ? -rem_acc : rem_acc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
